integrate_dump: RTL and testbench

Integrate-and-dump stage of the BPSK receiver data path. It sits directly downstream of the post-mixer multiplier and consumes that stage's 16.16 signed product stream and its `flag_in` qualifier. It accumulates a fixed number of qualified samples per symbol and emits the saturated symbol sum with a hard bit decision and a one-cycle output flag. A small FSM holds the block idle until the first symbol-alignment pulse after reset.

---
 rtl/integrate_dump.sv | 109 ++++++++++
 tb/tb_integrate_dump.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/integrate_dump.sv
// Integrate-and-dump for the BPSK receiver: sums N qualified 16.16 samples per
// symbol and emits a saturated sum, a hard bit decision and a one-cycle flag.
module integrate_dump #(
  parameter int SAMPLES_PER_SYM = 16,
  parameter int ACC_W           = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flag_in,
  input  logic signed [31:0] din,
  input  logic               sym_start,
  output logic signed [31:0] dump_out,
  output logic               bit_out,
  output logic               flag_out,
  output logic               ovf
);

  localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);

  typedef enum logic {WAIT_SYNC, INTEGRATE} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [31:0]        dump_q, dump_d;
  logic                      bit_q, bit_d;
  logic                      flag_q, flag_d;
  logic                      ovf_q, ovf_d;

  logic signed [ACC_W-1:0]   din_ext;
  logic signed [ACC_W-1:0]   sum;
  logic        [32:0]        sat_res;

  // Clamp to 32 bits; MSB of the result flags that clamping happened.
  function automatic logic [32:0] saturate32(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-32:0] hi;
    hi = v[ACC_W-1:31];
    if ((&hi) || !(|hi))
      saturate32 = {1'b0, v[31:0]};
    else if (v[ACC_W-1])
      saturate32 = {1'b1, 32'h8000_0000};
    else
      saturate32 = {1'b1, 32'h7FFF_FFFF};
  endfunction

  assign din_ext = {{(ACC_W-32){din[31]}}, din};
  assign sum     = acc_q + din_ext;
  assign sat_res = saturate32(sum);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dump_d  = dump_q;
    bit_d   = bit_q;
    flag_d  = 1'b0;
    ovf_d   = 1'b0;
    // Alignment pulse restarts the symbol from either state and beats a dump.
    if (sym_start) begin
      state_d = INTEGRATE;
      if (flag_in) begin
        acc_d = din_ext;
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (state_q == INTEGRATE && flag_in) begin
      if (cnt_q == LAST_CNT) begin
        dump_d = sat_res[31:0];
        ovf_d  = sat_res[32];
        bit_d  = ~sum[ACC_W-1];
        flag_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_SYNC;
      acc_q   <= '0;
      cnt_q   <= '0;
      dump_q  <= '0;
      bit_q   <= 1'b0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dump_q  <= dump_d;
      bit_q   <= bit_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dump_out = dump_q;
  assign bit_out  = bit_q;
  assign flag_out = flag_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_integrate_dump.sv
// Scoreboard bench for integrate_dump (N=4): stimulus pushes expected dumps,
// a monitor pops and compares them whenever flag_out is seen.
module tb_integrate_dump;

  localparam int N = 4;

  logic               clk;
  logic               reset;
  logic               flag_in;
  logic signed [31:0] din;
  logic               sym_start;
  logic signed [31:0] dump_out;
  logic               bit_out;
  logic               flag_out;
  logic               ovf;

  integrate_dump #(.SAMPLES_PER_SYM(N), .ACC_W(40)) dut (
    .clk(clk), .reset(reset), .flag_in(flag_in), .din(din), .sym_start(sym_start),
    .dump_out(dump_out), .bit_out(bit_out), .flag_out(flag_out), .ovf(ovf)
  );

  typedef struct {
    logic [31:0] d;
    logic        b;
    logic        o;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  logic prev_flag = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Drive one cycle of inputs; called at posedge+1 so the falling edge samples them.
  task automatic drive(input logic fi, input logic [31:0] d, input logic ss);
    flag_in   = fi;
    din       = d;
    sym_start = ss;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic expect_dump(input logic [31:0] d, input logic b, input logic o);
    exp_t e;
    e.d = d; e.b = b; e.o = o; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  // Send an N-sample symbol; the last sample carries the expectation.
  task automatic symbol(input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] s3,
                        input logic [31:0] d, input logic b, input logic o,
                        input int max_gap);
    drive(1'b1, s0, 1'b0); idle($urandom_range(0, max_gap));
    drive(1'b1, s1, 1'b0); idle($urandom_range(0, max_gap));
    drive(1'b1, s2, 1'b0); idle($urandom_range(0, max_gap));
    expect_dump(d, b, o);
    drive(1'b1, s3, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (flag_out) begin
      chk("flag_width", {63'd0, prev_flag}, 64'd0);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_dump: got dump_out=0x%08h, expected no flag_out", dump_out);
      end else begin
        e = sb.pop_front();
        chk("dump_out", {32'd0, dump_out}, {32'd0, e.d});
        chk("bit_out", {63'd0, bit_out}, {63'd0, e.b});
        chk("ovf", {63'd0, ovf}, {63'd0, e.o});
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
    prev_flag = flag_out;
  end

  initial begin
    reset = 1'b0; flag_in = 1'b0; din = '0; sym_start = 1'b0;
    repeat (3) @(posedge clk);
    chk("rst_dump", {32'd0, dump_out}, 64'd0);
    chk("rst_bit", {63'd0, bit_out}, 64'd0);
    chk("rst_flag", {63'd0, flag_out}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // No alignment pulse: samples must be ignored.
    for (int i = 0; i < 20; i++) drive(1'b1, 32'h0001_0000, 1'b0);
    idle(2);
    chk("nosync_dump", {32'd0, dump_out}, 64'd0);
    chk("nosync_bit", {63'd0, bit_out}, 64'd0);
    chk("nosync_ovf", {63'd0, ovf}, 64'd0);

    // Basic symbol with random gaps.
    drive(1'b0, 32'h0, 1'b1);
    symbol(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
           32'h0004_0000, 1'b1, 1'b0, 3);
    idle(2);

    // Negative sum followed back-to-back by a positive symbol.
    symbol(32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_8000,
           32'hFFFD_8000, 1'b0, 1'b0, 0);
    symbol(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000,
           32'h0008_0000, 1'b1, 1'b0, 0);
    idle(2);
    chk("hold_dump", {32'd0, dump_out}, 64'h0008_0000);
    chk("hold_bit", {63'd0, bit_out}, 64'd1);

    // Positive saturation, then ovf must drop.
    symbol(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
           32'h7FFF_FFFF, 1'b1, 1'b1, 0);
    idle(1);
    chk("ovf_drop", {63'd0, ovf}, 64'd0);
    chk("flag_drop", {63'd0, flag_out}, 64'd0);
    symbol(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
           32'h8000_0000, 1'b0, 1'b1, 1);
    // Largest unclamped value and an exact-zero sum.
    symbol(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    symbol(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    symbol(32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 0);
    idle(2);

    // Realign with a coincident sample discards the partial symbol.
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b1, 32'h0003_0000, 1'b1);
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    expect_dump(32'h0006_0000, 1'b1, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    idle(2);

    // Realign coincident with what would be the dump sample.
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b1, 32'h0005_0000, 1'b1);
    chk("realign_noflag", {63'd0, flag_out}, 64'd0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    expect_dump(32'h0008_0000, 1'b1, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    idle(2);

    // Realign without a sample mid-symbol.
    drive(1'b1, 32'h0004_0000, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    symbol(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
           32'h0004_0000, 1'b1, 1'b0, 2);
    symbol(32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0000_0001, 1'b1, 1'b0, 0);
    idle(2);
    chk("pre_rst_dump", {32'd0, dump_out}, 64'h0000_0001);

    // Asynchronous reset mid-symbol clears outputs before any clock edge.
    drive(1'b1, 32'h0009_0000, 1'b0);
    drive(1'b1, 32'h0009_0000, 1'b0);
    drive(1'b1, 32'h0009_0000, 1'b0);
    flag_in = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_dump", {32'd0, dump_out}, 64'd0);
    chk("async_bit", {63'd0, bit_out}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Back in WAIT_SYNC: lone sample ignored, sync coincident with first sample.
    drive(1'b1, 32'h0007_0000, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b1);
    drive(1'b1, 32'h0001_0000, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);
    expect_dump(32'h0004_0000, 1'b1, 1'b0);
    drive(1'b1, 32'h0001_0000, 1'b0);

    begin
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 20) begin
        idle(1);
        budget++;
      end
    end
    idle(2);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
